// File: rtl/ifid_queue_pkg.sv
// Shared CPU definitions for the IF/ID queue: the entry layout, the MIPS32
// decode-field bit positions, the NOP encoding and the PC step.
package ifid_queue_pkg;

  localparam int CPU_IW = 32;
  localparam int CPU_AW = 32;

  // MIPS32 field positions
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 25;
  localparam int JADDR_LSB = 0;
  localparam int SEL_MSB   = 2;
  localparam int SEL_LSB   = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_STEP   = 4;

  // Default-width entry (instruction, its PC, fetch address-error flag)
  typedef struct packed {
    logic [CPU_IW-1:0] instr;
    logic [CPU_AW-1:0] pc;
    logic              exc;
  } ifid_entry_t;

endpackage

// File: rtl/ifid_fifo_core.sv
// Circular FIFO core: read/write pointers, occupancy count and storage for an
// arbitrary packed entry type. Head entry is presented combinationally; the
// storage array is never reset (consumers gate it with rd_valid).
module ifid_fifo_core
  import ifid_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ifid_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  entry_t                   wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            push;
  logic            pop;

  // Handshake flags come only from the registered count
  assign wr_ready = (count != CW'(DEPTH));
  assign rd_valid = (count != '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem[rptr];

  // Pointer and count update; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; a push dropped by flush does not touch the array
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/ifid_queue.sv
// IF/ID stage buffer: DEPTH-entry FIFO between fetch and decode with
// pre-split MIPS32 decode fields, PC and PC+4 for the head entry. All id_*
// data outputs read zero while the queue is empty.
// Optional feature macro IFID_EXC_EN: carries a fetch address-error flag per
// entry; a flagged head reads as NOP while keeping its PC.
module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [IW-1:0]          if_instr,
  input  logic [AW-1:0]          if_pc,
`ifdef IFID_EXC_EN
  input  logic                   if_exc_adel,
  output logic                   id_exc_adel,
`endif
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [IW-1:0]          id_instr,
  output logic [4:0]             id_rs,
  output logic [4:0]             id_rt,
  output logic [4:0]             id_rd,
  output logic [15:0]            id_imm16,
  output logic [25:0]            id_jumpaddr,
  output logic [2:0]             id_sel,
  output logic [AW-1:0]          id_pc,
  output logic [AW-1:0]          id_pcadd4,
  output logic [$clog2(DEPTH):0] count
);

`ifdef IFID_EXC_EN
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          exc;
  } entry_t;
`else
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;
`endif

  entry_t        wr_entry;
  entry_t        head;
  logic          head_exc;
  logic          show_instr;
  logic [IW-1:0] instr_g;

  assign wr_entry.instr = if_instr;
  assign wr_entry.pc    = if_pc;
`ifdef IFID_EXC_EN
  assign wr_entry.exc   = if_exc_adel;
  assign head_exc       = head.exc;
  assign id_exc_adel    = id_valid && head.exc;
`else
  assign head_exc       = 1'b0;
`endif

  ifid_fifo_core #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (if_valid),
    .wr_ready (if_ready),
    .wr_data  (wr_entry),
    .rd_valid (id_valid),
    .rd_ready (id_ready),
    .rd_data  (head),
    .count    (count)
  );

  // Instruction is shown only for a valid, non-faulting head; otherwise NOP
  assign show_instr = id_valid && !head_exc;
  assign instr_g    = show_instr ? head.instr : IW'(NOP_INSTR);

  assign id_instr    = instr_g;
  assign id_rs       = instr_g[RS_MSB:RS_LSB];
  assign id_rt       = instr_g[RT_MSB:RT_LSB];
  assign id_rd       = instr_g[RD_MSB:RD_LSB];
  assign id_imm16    = instr_g[IMM_MSB:IMM_LSB];
  assign id_jumpaddr = instr_g[JADDR_MSB:JADDR_LSB];
  assign id_sel      = instr_g[SEL_MSB:SEL_LSB];

  // PC outputs keep the faulting PC but are zero when nothing is held
  assign id_pc     = id_valid ? head.pc : '0;
  assign id_pcadd4 = id_valid ? (head.pc + AW'(PC_STEP)) : '0;

endmodule

// File: doc/ifid_queue.md
# ifid_queue

Parametrised IF/ID stage buffer, successor to the single-entry IF/ID register. Sits between instruction fetch and decode. Holds up to DEPTH fetched instructions in a circular FIFO with valid/ready handshakes on both sides, and a synchronous flush. Presents pre-split decode fields (rs, rt, rd, imm16, jump target, sel) plus PC and PC+4 for the head entry, so fetch can run ahead of a stalled decode without losing instructions.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, ≥2.
- IW, 32: instruction width; fields below assume MIPS32 encoding.
- AW, 32: PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all entries.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  queue accepts; equals !full.
- if_instr  in  IW  fetched instruction.
- if_pc  in  AW  PC of if_instr.
- id_valid  out  1  head entry valid; equals count != 0.
- id_ready  in  1  decode consumes head this cycle.
- id_instr  out  IW  head instruction.
- id_rs / id_rt / id_rd  out  5 each  instr[25:21] / [20:16] / [15:11].
- id_imm16  out  16  instr[15:0].
- id_jumpaddr  out  26  instr[25:0].
- id_sel  out  3  instr[2:0].
- id_pc  out  AW  head PC.
- id_pcadd4  out  AW  head PC + 4, modulo 2^AW.
- count  out  $clog2(DEPTH)+1  entries held.
- if_exc_adel / id_exc_adel  in/out  1  fetch address-error flag (only with IFID_EXC_EN).

## Operation
- push = if_valid && if_ready; pop = id_valid && id_ready.
- Storage: DEPTH entries {instr, pc[, exc]}; write pointer, read pointer ($clog2(DEPTH) bits, natural wrap at DEPTH-1→0), count register.
- push only: write at wptr, wptr+1, count+1. pop only: rptr+1, count-1. Both: both pointers advance, count unchanged.
- Full (count==DEPTH): if_ready=0; no same-cycle pass-through, so push is impossible even if pop occurs.
- Empty: id_valid=0; pop impossible; no combinational bypass from if_* to id_*.
- All id_* data outputs (fields, pc, pcadd4, exc) are forced to zero when id_valid=0; otherwise combinationally derived from entry[rptr].
- flush=1: next edge sets wptr=rptr=count=0; dominates push and pop in the same cycle (pushed instruction dropped, pop has no effect).
- Storage array is not reset; outputs stay deterministic through zero-gating.

## Timing
- Reset (rst=0, asynchronous): count=0, pointers=0, id_valid=0, if_ready=1, all id_* outputs 0.
- Push-to-visible latency: 1 cycle (instruction accepted at edge N appears at id_* after edge N when queue was empty).
- Throughput: one push and one pop per cycle sustained.
- if_ready and id_valid depend only on registered count; no combinational path from id_ready to if_ready.
- Reset asserted mid-operation: all contents lost immediately; queue empty on deassertion.

## Configuration
- IFID_EXC_EN defined: each entry stores if_exc_adel; id_exc_adel outputs it; when set, id_instr and all instruction fields read zero (NOP) while id_pc/id_pcadd4 keep the faulting PC.
- Not defined: if_exc_adel/id_exc_adel ports absent; entry is {instr, pc}.

## Structure
- Shared package (CPU defines): ifid_entry_t struct {instr, pc, exc}, field-position constants (RS_MSB/LSB etc.), NOP encoding 32'h0.
- One sub-module: ifid_fifo_core (pointer/count/storage logic, generic over entry type); ifid_queue wraps it with field extraction, PC+4 adder and zero-gating.

## Test plan
- Reset: rst=0 → count=0, if_ready=1, id_valid=0, id_instr=0, id_pcadd4=0.
- Fields: push 32'h8CA30010 at pc 32'hBFC00000, id_ready=0 → next cycle id_rs=5, id_rt=3, id_rd=0, id_imm16=16'h0010, id_jumpaddr=26'h0A30010, id_sel=0, id_pcadd4=32'hBFC00004.
- Full/order (DEPTH=4): push I0..I4 with id_ready=0 → count=4, if_ready=0 after 4th, I4 held; then id_ready=1 → I0,I1,I2,I3 in order, count 0, id_valid=0.
- Simultaneous: count=2, push and pop same cycle → count stays 2, head advances, new entry at tail; repeat 8 cycles to exercise pointer wrap.
- Flush: full queue, flush=1 with if_valid=1 and id_ready=1 → next cycle count=0, id_valid=0, pushed instruction never appears.
- Wrap/exc: pc 32'hFFFFFFFC → id_pcadd4=0; with IFID_EXC_EN and if_exc_adel=1 → id_exc_adel=1, id_instr=0, id_pc=32'hFFFFFFFC.
